// File: rtl/cpu_pkg.sv
// Shared CPU control encodings: hazard-controller FSM states, stall causes
// and the load-use hazard detector used by the pipeline control logic.
package cpu_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DIV_WAIT = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_FLUSH   = 3'd1,
        CAUSE_MEM     = 3'd2,
        CAUSE_DIV     = 3'd3,
        CAUSE_LOADUSE = 3'd4,
        CAUSE_BRANCH  = 3'd5
    } stall_cause_e;

    // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hazard(input logic       memread,
                                             input logic [4:0] wreg,
                                             input logic [4:0] rs,
                                             input logic [4:0] rt);
        return memread && (wreg != 5'd0) && ((wreg == rs) || (wreg == rt));
    endfunction

endpackage

// File: rtl/div_cycle_cnt.sv
// Divide occupancy counter: loads the cycle budget, counts down to zero and
// reports when it has reached zero.
module div_cycle_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: stage enables/clears for exceptions,
// memory waits, multi-cycle divides, load-use stalls and taken branches.
// Optional stall-cycle performance counter enabled by PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       e_memread,
    input  logic [4:0] e_wreg,
    input  logic       d_branch_taken,
    input  logic       e_div_start,
    input  logic       mem_req,
    input  logic       mem_ack,
    input  logic       exc_flush,
    output logic       en_fd,
    output logic       en_de,
    output logic       en_em,
    output logic       en_mw,
    output logic       clr_fd,
    output logic       clr_de,
    output logic       clr_em,
    output logic       clr_mw,
    output logic       div_busy,
    output logic       div_done
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    stall_cause_e cause;
    logic         mem_hold;
    logic         div_hold;
    logic         div_finish;
    logic         launch;
    logic         load_use;
    logic         cnt_zero;

    assign load_use   = load_use_hazard(e_memread, e_wreg, d_rs, d_rt);
    assign mem_hold   = ((state == ST_RUN) && mem_req && !mem_ack) ||
                        ((state == ST_MEM_WAIT) && !mem_ack);
    assign div_hold   = (state == ST_DIV_WAIT) && !cnt_zero;
    assign div_finish = (state == ST_DIV_WAIT) && cnt_zero;

    // The finishing divide is still in E, so its start flag must not relaunch it;
    // a memory-ack cycle is an advancing cycle and may launch a deferred divide.
    always_comb begin
        cause     = CAUSE_NONE;
        state_nxt = ST_RUN;
        if (exc_flush) begin
            cause = CAUSE_FLUSH;
        end else if (mem_hold) begin
            cause     = CAUSE_MEM;
            state_nxt = ST_MEM_WAIT;
        end else if (div_hold || (!div_finish && e_div_start)) begin
            cause     = CAUSE_DIV;
            state_nxt = ST_DIV_WAIT;
        end else if (load_use) begin
            cause = CAUSE_LOADUSE;
        end else if (d_branch_taken) begin
            cause = CAUSE_BRANCH;
        end
    end

    assign launch = (cause == CAUSE_DIV) && (state != ST_DIV_WAIT);

    always_comb begin
        {en_fd, en_de, en_em, en_mw}     = 4'b1111;
        {clr_fd, clr_de, clr_em, clr_mw} = 4'b0000;
        div_busy = 1'b0;
        div_done = 1'b0;
        if (rst) begin
            {en_fd, en_de, en_em, en_mw}     = 4'b0000;
            {clr_fd, clr_de, clr_em, clr_mw} = 4'b1111;
        end else begin
            case (cause)
                CAUSE_FLUSH:   {clr_fd, clr_de, clr_em, clr_mw} = 4'b1111;
                CAUSE_MEM:     {en_fd, en_de, en_em, en_mw} = 4'b0000;
                CAUSE_DIV: begin
                    {en_fd, en_de, en_em, en_mw}     = 4'b0001;
                    {clr_fd, clr_de, clr_em, clr_mw} = 4'b0001;
                end
                CAUSE_LOADUSE: begin
                    en_fd  = 1'b0;
                    clr_de = 1'b1;
                end
                CAUSE_BRANCH:  clr_fd = 1'b1;
                default: ;
            endcase
            div_busy = (state == ST_DIV_WAIT) || launch;
            div_done = div_finish && !exc_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    div_cycle_cnt #(
        .CNT_W (CNT_W)
    ) u_div_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (exc_flush),
        .load     (launch),
        .dec      (div_hold),
        .load_val (CNT_W'(DIV_CYCLES - 1)),
        .zero     (cnt_zero)
    );

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (!en_fd) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, multi-cycle corner
// sequences and randomized cycles against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int DIV_CYCLES = 4;

    typedef struct packed {
        logic       rst;
        logic       flush;
        logic       memreq;
        logic       memack;
        logic       divstart;
        logic       memread;
        logic [4:0] wreg;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
    } in_t;

    typedef struct {
        in_t         stim;
        logic [9:0]  exp;
        string       name;
    } vec_t;

    // Expected output words: {en_fd,en_de,en_em,en_mw, clr_fd,clr_de,clr_em,clr_mw, busy, done}
    localparam logic [9:0] X_RST  = {4'b0000, 4'b1111, 2'b00};
    localparam logic [9:0] X_NORM = {4'b1111, 4'b0000, 2'b00};
    localparam logic [9:0] X_LU   = {4'b0111, 4'b0100, 2'b00};
    localparam logic [9:0] X_BR   = {4'b1111, 4'b1000, 2'b00};
    localparam logic [9:0] X_FL   = {4'b1111, 4'b1111, 2'b00};
    localparam logic [9:0] X_FLB  = {4'b1111, 4'b1111, 2'b10};
    localparam logic [9:0] X_MEM  = {4'b0000, 4'b0000, 2'b00};
    localparam logic [9:0] X_DIV  = {4'b0001, 4'b0001, 2'b10};
    localparam logic [9:0] X_DONE = {4'b1111, 4'b0000, 2'b11};

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] d_rs, d_rt, e_wreg;
    logic       e_memread, d_branch_taken, e_div_start, mem_req, mem_ack, exc_flush;
    logic       en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw;
    logic       div_busy, div_done;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = flowing, 1 = waiting on memory, 2 = divide in progress
    int         mdl_mode = 0;
    int         mdl_left = 0;
    int         nxt_mode;
    int         nxt_left;
    logic [9:0] mdl_exp;
    int unsigned mdl_perf = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .d_rs           (d_rs),
        .d_rt           (d_rt),
        .e_memread      (e_memread),
        .e_wreg         (e_wreg),
        .d_branch_taken (d_branch_taken),
        .e_div_start    (e_div_start),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .exc_flush      (exc_flush),
        .en_fd          (en_fd),
        .en_de          (en_de),
        .en_em          (en_em),
        .en_mw          (en_mw),
        .clr_fd         (clr_fd),
        .clr_de         (clr_de),
        .clr_em         (clr_em),
        .clr_mw         (clr_mw),
        .div_busy       (div_busy),
        .div_done       (div_done)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic in_t mk(input logic r, input logic fl, input logic mrq, input logic mak,
                               input logic dv, input logic mrd, input logic [4:0] wr,
                               input logic [4:0] s, input logic [4:0] t, input logic b);
        in_t v;
        v.rst = r; v.flush = fl; v.memreq = mrq; v.memack = mak; v.divstart = dv;
        v.memread = mrd; v.wreg = wr; v.rs = s; v.rt = t; v.br = b;
        return v;
    endfunction

    task automatic applyStimulus(input in_t v);
        @(negedge clk);
        rst            = v.rst;
        exc_flush      = v.flush;
        mem_req        = v.memreq;
        mem_ack        = v.memack;
        e_div_start    = v.divstart;
        e_memread      = v.memread;
        e_wreg         = v.wreg;
        d_rs           = v.rs;
        d_rt           = v.rt;
        d_branch_taken = v.br;
    endtask

    // Expected behaviour derived from the pipeline rules in priority order.
    task automatic modelEval(input in_t v);
        logic hazard;
        logic may_launch;
        hazard     = v.memread && (v.wreg != 0) && (v.wreg == v.rs || v.wreg == v.rt);
        may_launch = 1'b1;
        mdl_exp    = X_NORM;
        nxt_mode   = 0;
        nxt_left   = 0;
        if (v.rst) begin
            mdl_exp = X_RST;
            return;
        end
        if (v.flush) begin
            mdl_exp    = X_FL;
            mdl_exp[1] = (mdl_mode == 2);
            return;
        end
        if (mdl_mode == 2) begin
            if (mdl_left > 1) begin
                mdl_exp  = X_DIV;
                nxt_mode = 2;
                nxt_left = mdl_left - 1;
                return;
            end
            mdl_exp[1:0] = 2'b11;
            may_launch   = 1'b0;
        end else if ((mdl_mode == 0 && v.memreq && !v.memack) || (mdl_mode == 1 && !v.memack)) begin
            mdl_exp  = X_MEM;
            nxt_mode = 1;
            return;
        end
        if (may_launch && v.divstart) begin
            mdl_exp  = X_DIV;
            nxt_mode = 2;
            nxt_left = DIV_CYCLES;
            return;
        end
        if (hazard) begin
            mdl_exp[9:2] = {4'b0111, 4'b0100};
        end else if (v.br) begin
            mdl_exp[5] = 1'b1;
        end
    endtask

    task automatic modelCommit(input in_t v);
        mdl_mode = nxt_mode;
        mdl_left = nxt_left;
        if (v.rst) mdl_perf = 0;
        else if (!mdl_exp[9]) mdl_perf = mdl_perf + 1;
    endtask

    task automatic checkOutput(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw, div_busy, div_done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (en4 clr4 busy done)", name, act, exp);
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        checks++;
        if (perf_stall_cnt !== mdl_perf) begin
            errors++;
            $display("[TB] FAIL %s perf_stall_cnt: got %0d expected %0d", name, perf_stall_cnt, mdl_perf);
        end
`endif
    endtask

    task automatic stepCycle(input in_t v, input logic [9:0] exp, input logic use_model,
                             input string name);
        applyStimulus(v);
        modelEval(v);
        #1;
        checkOutput(name, use_model ? mdl_exp : exp);
        @(posedge clk);
        modelCommit(v);
    endtask

    task automatic resetDut();
        in_t v;
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            applyStimulus(v);
            modelEval(v);
            @(posedge clk);
            modelCommit(v);
        end
    endtask

    vec_t tbl[$];
    in_t  idle;
    in_t  rv;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetDut();

        tbl.push_back('{mk(1,0,0,0,0,0,5'd0,5'd0,5'd0,0), X_RST,  "reset_held"});
        tbl.push_back('{mk(0,0,0,0,0,0,5'd0,5'd0,5'd0,0), X_NORM, "normal"});
        tbl.push_back('{mk(0,0,0,0,0,1,5'd5,5'd5,5'd1,0), X_LU,   "loaduse_rs"});
        tbl.push_back('{mk(0,0,0,0,0,1,5'd9,5'd2,5'd9,0), X_LU,   "loaduse_rt"});
        tbl.push_back('{mk(0,0,0,0,0,1,5'd0,5'd0,5'd0,0), X_NORM, "load_r0_no_hazard"});
        tbl.push_back('{mk(0,0,0,0,0,0,5'd7,5'd7,5'd7,0), X_NORM, "no_memread"});
        tbl.push_back('{mk(0,0,0,0,0,1,5'd7,5'd6,5'd8,0), X_NORM, "load_no_match"});
        tbl.push_back('{mk(0,0,0,0,0,0,5'd0,5'd0,5'd0,1), X_BR,   "branch"});
        tbl.push_back('{mk(0,0,0,0,0,1,5'd3,5'd3,5'd0,1), X_LU,   "branch_under_loaduse"});
        tbl.push_back('{mk(0,1,0,0,0,1,5'd3,5'd3,5'd0,1), X_FL,   "flush_over_all"});
        tbl.push_back('{mk(0,1,1,0,1,0,5'd0,5'd0,5'd0,0), X_FL,   "flush_over_mem_div"});
        tbl.push_back('{mk(0,0,1,1,0,0,5'd0,5'd0,5'd0,0), X_NORM, "mem_req_ack_same"});
        tbl.push_back('{mk(0,0,1,1,0,0,5'd0,5'd0,5'd0,1), X_BR,   "mem_ack_branch"});

        foreach (tbl[k]) stepCycle(tbl[k].stim, tbl[k].exp, 1'b0, tbl[k].name);

        // Load-use gives exactly one bubble
        stepCycle(mk(0,0,0,0,0,1,5'd5,5'd5,5'd0,0), X_LU,   1'b0, "lu_bubble");
        stepCycle(idle,                               X_NORM, 1'b0, "lu_after");

        // Divide of DIV_CYCLES with the start flag held while the divide sits in E
        for (int i = 0; i < DIV_CYCLES; i++)
            stepCycle(mk(0,0,0,0,1,0,0,0,0,0), X_DIV, 1'b0, "div_stall");
        stepCycle(mk(0,0,0,0,1,0,0,0,0,0), X_DONE, 1'b0, "div_done");
        stepCycle(idle,                     X_NORM, 1'b0, "div_after");

        // Memory wait of three cycles
        for (int i = 0; i < 3; i++)
            stepCycle(mk(0,0,1,0,0,0,0,0,0,0), X_MEM, 1'b0, "mem_wait");
        stepCycle(mk(0,0,1,1,0,0,0,0,0,0), X_NORM, 1'b0, "mem_ack");

        // Divide start deferred behind a memory stall
        stepCycle(mk(0,0,1,0,1,0,0,0,0,0), X_MEM, 1'b0, "defer_mem");
        stepCycle(mk(0,0,1,1,1,0,0,0,0,0), X_DIV, 1'b0, "defer_launch");
        for (int i = 0; i < DIV_CYCLES - 1; i++)
            stepCycle(mk(0,0,0,0,1,0,0,0,0,0), X_DIV, 1'b0, "defer_stall");
        stepCycle(mk(0,0,0,0,1,0,0,0,0,0), X_DONE, 1'b0, "defer_done");

        // Exception on the second divide-wait cycle
        stepCycle(mk(0,0,0,0,1,0,0,0,0,0), X_DIV,  1'b0, "exc_launch");
        stepCycle(mk(0,0,0,0,1,0,0,0,0,0), X_DIV,  1'b0, "exc_wait1");
        stepCycle(mk(0,1,0,0,1,0,0,0,0,0), X_FLB,  1'b0, "exc_flush_div");
        stepCycle(idle,                     X_NORM, 1'b0, "exc_after");

        // Branch suppressed by load-use, then re-resolved
        stepCycle(mk(0,0,0,0,0,1,5'd4,5'd0,5'd4,1), X_LU, 1'b0, "br_lu");
        stepCycle(mk(0,0,0,0,0,0,5'd0,5'd0,5'd0,1), X_BR, 1'b0, "br_retry");

        // Reset abandons a memory wait
        stepCycle(mk(0,0,1,0,0,0,0,0,0,0), X_MEM,  1'b0, "rst_mem_stall");
        stepCycle(mk(1,0,1,0,0,0,0,0,0,0), X_RST,  1'b0, "rst_mem_hold1");
        stepCycle(mk(1,0,1,0,0,0,0,0,0,0), X_RST,  1'b0, "rst_mem_hold2");
        stepCycle(idle,                     X_NORM, 1'b0, "rst_mem_release");

        // Reset abandons a divide
        stepCycle(mk(0,0,0,0,1,0,0,0,0,0), X_DIV,  1'b0, "rst_div_launch");
        stepCycle(mk(0,0,0,0,1,0,0,0,0,0), X_DIV,  1'b0, "rst_div_wait");
        stepCycle(mk(1,0,0,0,1,0,0,0,0,0), X_RST,  1'b0, "rst_div_hold");
        stepCycle(idle,                     X_NORM, 1'b0, "rst_div_release");

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            rv = mk($urandom_range(0, 63) == 0,
                    $urandom_range(0, 31) == 0,
                    $urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0,
                    1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    $urandom_range(0, 3) == 0);
            stepCycle(rv, X_NORM, 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
